// File: rtl/forward_hazard_unit.sv
// EX operand forwarding select and load-use stall generation for a 5-stage pipeline.
// Optional stall-cycle counter (port stall_count) is built only when HAZARD_STATS_EN is defined.
module forward_hazard_unit #(
    parameter int REG_BITS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regWrite,
    input  logic                id_memRead,
    input  logic                flush,
    output logic [1:0]          fwdA,
    output logic [1:0]          fwdB,
    output logic                stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]    stall_count
`endif
);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } meta_t;

    typedef enum logic {RUN, HOLD} state_t;

    meta_t  ex, mem, wb_unused;
    meta_t  id_meta;
    state_t state, state_next;
    logic   load_use;
    logic   accept;

    function automatic logic writes(input meta_t m, input logic [REG_BITS-1:0] r);
        return m.valid && m.reg_write && (m.rd == r) && (r != '0);
    endfunction

    // Newest producer wins: the instruction now in EX will be in MEM when the consumer executes.
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] r);
        if (writes(ex, r))
            return 2'b01;
        else if (writes(mem, r))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign id_meta  = '{valid: 1'b1, rd: id_rd, reg_write: id_regWrite, mem_read: id_memRead};
    assign load_use = id_valid && ex.mem_read && (writes(ex, id_rs1) || writes(ex, id_rs2));
    assign stall    = rst_n && (state == RUN) && load_use && !flush;
    assign accept   = id_valid && !stall && !flush;

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (stall) state_next = HOLD;
            HOLD:    state_next = RUN;
            default: state_next = RUN;
        endcase
        if (flush)
            state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    // WB metadata is carried for completeness; nothing downstream of WB needs it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex        <= '0;
            mem       <= '0;
            wb_unused <= '0;
            fwdA      <= 2'b00;
            fwdB      <= 2'b00;
        end else begin
            wb_unused <= mem;
            mem       <= ex;
            if (accept) begin
                ex   <= id_meta;
                fwdA <= fwd_sel(id_rs1);
                fwdB <= fwd_sel(id_rs2);
            end else begin
                ex   <= '0;
                fwdA <= 2'b00;
                fwdB <= 2'b00;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed pipeline sequences plus random traffic against
// a history-list reference model; stall_count is checked when HAZARD_STATS_EN is defined.
module tb_forward_hazard_unit;

    localparam int RB = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [RB-1:0] id_rs1, id_rs2, id_rd;
    logic          id_regWrite, id_memRead, flush;
    logic [1:0]    fwdA, fwdB;
    logic          stall;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    forward_hazard_unit #(.REG_BITS(RB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead), .flush(flush),
        .fwdA(fwdA), .fwdB(fwdB), .stall(stall)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: h_*[0] is the instruction that most recently entered EX, [1] the one before it.
    bit h_v[2];
    int h_rd[2];
    bit h_w[2];
    bit h_l[2];
    int exp_cnt;
    bit last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit produces(input int k, input int r);
        return h_v[k] && h_w[k] && h_rd[k] == r && r != 0;
    endfunction

    function automatic int sel(input int r);
        if (produces(0, r)) return 1;
        if (produces(1, r)) return 2;
        return 0;
    endfunction

    // One cycle: drive ID, check stall, clock, check the registered selects.
    task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                        input bit w, input bit l, input bit fl, input string tag);
        bit es, acc;
        int ea, eb;
        id_valid = v; id_rs1 = RB'(rs1); id_rs2 = RB'(rs2); id_rd = RB'(rd);
        id_regWrite = w; id_memRead = l; flush = fl;
        #1;
        es = rst_n && v && !fl && h_l[0] && (produces(0, rs1) || produces(0, rs2));
        chk({tag, "_stall"}, 32'(stall), 32'(es));
        acc = rst_n && v && !es && !fl;
        ea  = acc ? sel(rs1) : 0;
        eb  = acc ? sel(rs2) : 0;
        if (!rst_n) exp_cnt = 0;
        else if (es && exp_cnt < (1 << CW) - 1) exp_cnt++;
        @(posedge clk);
        #1;
        h_v[1] = rst_n ? h_v[0] : 0; h_rd[1] = h_rd[0]; h_w[1] = h_w[0]; h_l[1] = h_l[0];
        h_v[0] = acc; h_rd[0] = rd; h_w[0] = w; h_l[0] = l;
        last_stall = es;
        chk({tag, "_fwdA"}, 32'(fwdA), 32'(ea));
        chk({tag, "_fwdB"}, 32'(fwdB), 32'(eb));
`ifdef HAZARD_STATS_EN
        chk({tag, "_cnt"}, 32'(stall_count), 32'(exp_cnt));
`endif
    endtask

    initial begin
        int r1, r2, rd;
        bit v, w, l, fl;
        h_v = '{0, 0}; h_rd = '{0, 0}; h_w = '{0, 0}; h_l = '{0, 0};
        exp_cnt = 0; last_stall = 0;
        rst_n = 1'b0;
        // Reset with a would-be hazard on the inputs: stall must stay low.
        step(1, 2, 2, 2, 1, 1, 0, "rst0");
        step(1, 2, 2, 0, 1, 0, 0, "rst1");
        chk("rst_fwdA", 32'(fwdA), 32'd0);
        rst_n = 1'b1;

        // add r3 ; sub r4,r3,r5
        step(1, 1, 2, 3, 1, 0, 0, "add");
        step(1, 3, 5, 4, 1, 0, 0, "sub");
        chk("seq030_fwdA", 32'(fwdA), 32'd1);
        chk("seq030_fwdB", 32'(fwdB), 32'd0);

        // add r3 ; nop ; and r6,r7,r3
        step(1, 1, 2, 3, 1, 0, 0, "add2");
        step(0, 0, 0, 0, 0, 0, 0, "nop");
        step(1, 7, 3, 6, 1, 0, 0, "and");
        chk("seq031_fwdA", 32'(fwdA), 32'd0);
        chk("seq031_fwdB", 32'(fwdB), 32'd2);

        // lw r2 ; add r8,r2,r2 : one stall cycle then WB forwarding
        step(1, 1, 0, 2, 1, 1, 0, "lw");
        step(1, 2, 2, 8, 1, 0, 0, "lu_hz");
        chk("seq032_stall_seen", 32'(last_stall), 32'd1);
        chk("seq032_bubble", 32'(fwdA), 32'd0);
        step(1, 2, 2, 8, 1, 0, 0, "lu_go");
        chk("seq032_fwdA", 32'(fwdA), 32'd2);
        chk("seq032_fwdB", 32'(fwdB), 32'd2);

        // lw r2 ; add r8,r2,r1 with flush in the hazard cycle
        step(1, 1, 0, 2, 1, 1, 0, "lw2");
        step(1, 2, 1, 8, 1, 0, 1, "flush");
        chk("seq033_nostall", 32'(last_stall), 32'd0);

        // r0 writes never forward; r5 producers in EX and MEM -> EX wins
        step(1, 1, 1, 0, 1, 0, 0, "w0a");
        step(1, 1, 1, 0, 1, 0, 0, "w0b");
        step(1, 0, 0, 9, 1, 0, 0, "r0");
        chk("seq034_r0", 32'({fwdA, fwdB}), 32'd0);
        step(1, 1, 1, 5, 1, 0, 0, "w5a");
        step(1, 1, 1, 5, 1, 0, 0, "w5b");
        step(1, 5, 5, 9, 1, 0, 0, "r5");
        chk("seq034_r5", 32'(fwdA), 32'd1);

        // Saturate the counter with repeated load-use pairs.
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step(1, 1, 0, 2, 1, 1, 0, "sat_lw");
            step(1, 2, 0, 8, 1, 0, 0, "sat_hz");
            step(1, 2, 0, 8, 1, 0, 0, "sat_go");
        end

        // Reset asserted during HOLD.
        step(1, 1, 0, 2, 1, 1, 0, "h_lw");
        step(1, 2, 2, 8, 1, 0, 0, "h_hz");
        rst_n = 1'b0;
        step(1, 2, 2, 8, 1, 0, 0, "h_rst");
        rst_n = 1'b1;
        step(1, 2, 2, 8, 1, 0, 0, "h_after");
        chk("hold_rst_fwdB", 32'(fwdB), 32'd0);

        // Random traffic; a stalled instruction is re-presented until it goes through.
        r1 = 0; r2 = 0; rd = 0; v = 0; w = 0; l = 0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 9) < 8);
                r1 = $urandom_range(0, 3);
                r2 = $urandom_range(0, 3);
                rd = $urandom_range(0, 3);
                w  = ($urandom_range(0, 3) != 0);
                l  = ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            step(v, r1, r2, rd, w, l, fl, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter REG_BITS, default 4: register-index width; register 0 is hardwired zero.
REQ-002 Parameter CNT_W, default 16: stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2  in  REG_BITS each  ID source registers.
REQ-007 id_rd  in  REG_BITS  ID destination register.
REQ-008 id_regWrite, id_memRead  in  1 each  ID instruction writes rd / is a load.
REQ-009 flush  in  1  taken branch resolved in EX; kill ID instruction.
REQ-010 fwdA, fwdB  out  2 each  registered EX operand selects: 00 register file, 01 MEM-stage ALU result, 10 WB-stage result, 11 never driven.
REQ-011 stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
REQ-012 stall_count  out  CNT_W  stall-cycle counter (present only with HAZARD_STATS_EN).

Function
REQ-013 Unit SHALL keep metadata {valid, rd, regWrite, memRead} for EX, MEM and WB stages.
REQ-014 Each edge: WB <= MEM, MEM <= EX; EX <= ID metadata when id_valid & !stall & !flush, else bubble (valid=0).
REQ-015 Stage "writes r" SHALL mean valid & regWrite & rd==r & r!=0.
REQ-016 Load-use hazard SHALL mean id_valid & EX.memRead & EX writes id_rs1 or id_rs2.
REQ-017 stall SHALL equal load-use hazard & !flush; flush has priority.
REQ-018 FSM states RUN, HOLD: RUN->HOLD when stall=1; HOLD->RUN unconditionally next cycle (load now in MEM); flush in any state -> RUN.
REQ-019 In HOLD, stall SHALL be 0 for the same ID instruction, since its producer has left EX.
REQ-020 When EX loads from ID (REQ-014), fwdA SHALL register 01 if EX writes id_rs1, else 10 if MEM writes id_rs1, else 00; fwdB identical for id_rs2.
REQ-021 EX-stage match SHALL take priority over MEM-stage match (newest producer wins).
REQ-022 A load in MEM matching a source SHALL select 10, since load data reaches Result in WB.
REQ-023 When a bubble enters EX, fwdA/fwdB SHALL register 00.
REQ-024 Source register 0 SHALL always give select 00.
REQ-025 Latency: selects valid the cycle after the ID instruction is accepted; stall valid in the same cycle as the hazard.

Reset
REQ-026 rst_n=0 at an edge SHALL clear all stage valid bits, fwdA=fwdB=00, FSM=RUN and stall_count=0.
REQ-027 stall SHALL be 0 during and in the first cycle after reset; reset mid-HOLD returns to RUN.

Configuration
REQ-028 Macro HAZARD_STATS_EN: when defined, stall_count increments on each cycle with stall=1, saturates at all-ones, and clears only on reset.
REQ-029 Without HAZARD_STATS_EN, port stall_count and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 Sequence add r3; sub r4,r3,r5 -> cycle after sub is accepted, fwdA=01, fwdB=00, stall never 1.
REQ-031 Sequence add r3; nop; and r6,r7,r3 -> and enters EX with fwdB=10, fwdA=00.
REQ-032 Sequence lw r2; add r8,r2,r2 -> stall=1 for exactly 1 cycle, bubble in EX, then add enters EX with fwdA=fwdB=10; stall_count=1.
REQ-033 Sequence lw r2; add r8,r2,r1 with flush=1 in the hazard cycle -> stall=0, EX receives bubble, fwd=00, stall_count unchanged.
REQ-034 Writes to r0 followed by a read of r0 -> fwd=00; with producers of r5 in both EX and MEM, a read of r5 -> 01.
REQ-035 Force 2^CNT_W+3 load-use stalls (HAZARD_STATS_EN) -> stall_count holds 0xFFFF; rst_n=0 during HOLD -> next cycle stall=0 and all outputs equal their reset values.
